mem_port_arbiter: RTL and testbench

//  Shares the single cache-to-memory port (mem_req_type / mem_data_type) between NREQ requesters.

---
 rtl/cache_def.sv | 20 ++
 rtl/mem_port_arbiter_rr_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 101 ++++++++++
 tb/tb_mem_port_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_def.sv
// Shared cache/memory interface types and the memory-port arbiter state encoding.
package cache_def;

  parameter int NUM_MEM_REQ = 2;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: first valid index at or after rr_ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter  int NREQ  = 2,
  localparam int GNT_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [GNT_W-1:0] rr_ptr,
  output logic             any_valid,
  output logic [GNT_W-1:0] idx
);

  localparam int SW = GNT_W + 1;

  logic [GNT_W:0] slot;

  // Scan from the farthest offset back to rr_ptr so the nearest valid slot is written last.
  always_comb begin
    any_valid = |valid;
    idx       = '0;
    slot      = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      slot = {1'b0, rr_ptr} + SW'(k - 1);
      if (slot >= SW'(NREQ)) slot = slot - SW'(NREQ);
      if (valid[slot[GNT_W-1:0]]) idx = slot[GNT_W-1:0];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between NREQ requesters, one transaction at a time.
module mem_port_arbiter
  import cache_def::*;
#(
  parameter  int NREQ    = NUM_MEM_REQ,
  parameter  int TIMEOUT = 1023,
  localparam int GNT_W   = $clog2(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  mem_req_type     req_i [NREQ],
  output mem_data_type    rsp_o [NREQ],
  output mem_req_type     mem_req_o,
  input  mem_data_type    mem_rsp_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e       state;
  logic [GNT_W-1:0] rr_ptr;
  logic [GNT_W-1:0] gnt_idx;
  logic [GNT_W-1:0] pick_idx;
  logic             any_valid;
  logic [CNT_W-1:0] wait_cnt;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  rsp_ready;
  logic [127:0]     rsp_data;

  function automatic logic [NREQ-1:0] onehot(input logic [GNT_W-1:0] i);
    return NREQ'(1) << i;
  endfunction

  function automatic logic [GNT_W-1:0] next_ptr(input logic [GNT_W-1:0] i);
    return (i == GNT_W'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_port
    assign req_valid[i] = req_i[i].valid;
    assign rsp_o[i]     = '{data: rsp_data, ready: rsp_ready[i]};
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr),
    .any_valid (any_valid),
    .idx       (pick_idx)
  );

  // mem_req_o doubles as the request latch; its fields stay put through RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      wait_cnt  <= '0;
      mem_req_o <= '0;
      gnt_o     <= '0;
      busy_o    <= 1'b0;
      err_o     <= 1'b0;
      rsp_ready <= '0;
      rsp_data  <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (any_valid) begin
            state           <= ARB_BUSY;
            gnt_idx         <= pick_idx;
            rr_ptr          <= next_ptr(pick_idx);
            mem_req_o       <= req_i[pick_idx];
            mem_req_o.valid <= 1'b1;
            gnt_o           <= onehot(pick_idx);
            busy_o          <= 1'b1;
          end
        end
        ARB_BUSY: begin
          if (mem_rsp_i.ready) begin
            state           <= ARB_RESP;
            mem_req_o.valid <= 1'b0;
            rsp_data        <= mem_rsp_i.data;
            rsp_ready       <= onehot(gnt_idx);
          end else if (TIMEOUT > 0 && wait_cnt != CNT_W'(TIMEOUT)) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CNT_W'(TIMEOUT - 1)) err_o <= 1'b1;
          end
        end
        ARB_RESP: begin
          state     <= ARB_IDLE;
          rsp_ready <= '0;
          gnt_o     <= '0;
          busy_o    <= 1'b0;
          wait_cnt  <= '0;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized fairness soak against a reference model.
module tb_mem_port_arbiter;
  import cache_def::*;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  mem_req_type     req_i [NREQ];
  mem_data_type    rsp_o [NREQ];
  mem_req_type     mem_req_o;
  mem_data_type    mem_rsp_i;
  logic [NREQ-1:0] gnt_o;
  logic            busy_o;
  logic            err_o;

  mem_port_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .rsp_o     (rsp_o),
    .mem_req_o (mem_req_o),
    .mem_rsp_i (mem_rsp_i),
    .gnt_o     (gnt_o),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the port, which phase, pointer, wait count, sticky error.
  int           m_phase;   // 0 free, 1 waiting on memory, 2 handing back the response
  int           m_owner;
  int           m_rr;
  int           m_wait;
  bit           m_err;
  mem_req_type  m_req;
  logic [127:0] m_data;

  // Requesters.
  bit           pend     [NREQ];
  bit           auto_req [NREQ];
  logic [31:0]  p_addr   [NREQ];
  logic [127:0] p_data   [NREQ];
  bit           p_rw     [NREQ];
  int           pulses     [NREQ];
  int           dut_grants [NREQ];
  logic [NREQ-1:0] prev_gnt;

  // Memory.
  int           mem_lat;
  int           mem_seen;
  bit           mem_hold;
  bit           mem_rand_lat;
  bit           spurious_en;
  bit           use_fixed;
  logic [127:0] fixed_data;

  function automatic logic [127:0] exp_word(input logic [31:0] a);
    if (use_fixed) return fixed_data;
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1234_5678};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_rr = 0; m_wait = 0; m_err = 0;
    m_req = '0; m_data = '0;
  endtask

  task automatic model_edge();
    bit found;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        found = 0;
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (m_rr + k) % NREQ;
          if (!found && req_i[j].valid) begin
            found = 1;
            m_owner = j;
            m_req = req_i[j];
            m_req.valid = 1'b1;
            m_rr = (j + 1) % NREQ;
            m_phase = 1;
          end
        end
      end
      1: begin
        if (mem_rsp_i.ready) begin
          m_data = mem_rsp_i.data;
          m_phase = 2;
        end else if (TIMEOUT > 0 && m_wait < TIMEOUT) begin
          m_wait++;
          if (m_wait == TIMEOUT) m_err = 1;
        end
      end
      default: begin
        m_phase = 0;
        m_wait = 0;
      end
    endcase
  endtask

  task automatic compare();
    logic [NREQ-1:0] eg;
    eg = (m_phase == 0) ? '0 : (NREQ'(1) << m_owner);
    check("gnt_o", gnt_o, eg);
    check("busy_o", busy_o, m_phase != 0);
    check("err_o", err_o, m_err);
    check("mem_valid", mem_req_o.valid, m_phase == 1);
    if (m_phase == 1) begin
      check("mem_addr", mem_req_o.addr, m_req.addr);
      check("mem_data", mem_req_o.data, m_req.data);
      check("mem_rw", mem_req_o.rw, m_req.rw);
    end
    for (int i = 0; i < NREQ; i++) begin
      check($sformatf("rsp%0d_ready", i), rsp_o[i].ready, (m_phase == 2 && m_owner == i));
      if (rsp_o[i].ready) begin
        pulses[i]++;
        check($sformatf("rsp%0d_has_request", i), pend[i], 1'b1);
        if (!p_rw[i]) check($sformatf("rsp%0d_read_data", i), rsp_o[i].data, exp_word(p_addr[i]));
        if (m_phase == 2 && m_owner == i) check($sformatf("rsp%0d_model_data", i), rsp_o[i].data, m_data);
      end
    end
    if (gnt_o != '0 && prev_gnt == '0)
      for (int j = 0; j < NREQ; j++)
        if (gnt_o == (NREQ'(1) << j)) dut_grants[j]++;
    prev_gnt = gnt_o;
  endtask

  task automatic new_req(input int i);
    pend[i] = 1;
    p_addr[i] = $urandom & 32'hFFFF_FFF0;
    p_data[i] = rand128();
    p_rw[i] = $urandom_range(0, 1);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_i[i].valid = pend[i];
      req_i[i].addr  = p_addr[i];
      req_i[i].data  = p_data[i];
      req_i[i].rw    = p_rw[i];
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [127:0] d, input bit rw);
    pend[i] = 1; p_addr[i] = a; p_data[i] = d; p_rw[i] = rw;
    drive_reqs();
  endtask

  task automatic react();
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i] && rsp_o[i].ready) pend[i] = 0;
      if (!pend[i] && auto_req[i]) new_req(i);
    end
    drive_reqs();
    if (mem_req_o.valid) begin
      mem_seen++;
      if (mem_seen == 1 && mem_rand_lat) mem_lat = $urandom_range(1, 5);
      if (!mem_hold && mem_seen > mem_lat) begin
        mem_rsp_i.ready = 1'b1;
        mem_rsp_i.data  = exp_word(mem_req_o.addr);
      end else begin
        mem_rsp_i.ready = 1'b0;
        mem_rsp_i.data  = rand128();
      end
    end else begin
      mem_seen = 0;
      mem_rsp_i.ready = spurious_en && ($urandom_range(0, 3) == 0);
      mem_rsp_i.data  = rand128();
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    compare();
    react();
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    model_reset();
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic wait_grant(input int budget, output logic [NREQ-1:0] g);
    bit seen_idle;
    bit got;
    seen_idle = (gnt_o == '0);
    got = 0;
    g = '0;
    for (int c = 0; c < budget && !got; c++) begin
      step();
      if (seen_idle && gnt_o != '0) begin
        g = gnt_o;
        got = 1;
      end
      if (gnt_o == '0) seen_idle = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL grant_wait: no grant within %0d cycles, required one", budget);
    end
  endtask

  task automatic wait_ready(input int who, input int budget, output int cyc, output logic [127:0] d);
    cyc = -1;
    d = '0;
    for (int c = 1; c <= budget && cyc < 0; c++) begin
      step();
      if (rsp_o[who].ready) begin
        cyc = c;
        d = rsp_o[who].data;
      end
    end
    total++;
    if (cyc < 0) begin
      bad++;
      $display("FAIL ready_wait%0d: no ready within %0d cycles, required one", who, budget);
    end
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < NREQ; i++) if (pend[i]) return 1;
    return 0;
  endfunction

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((any_pend() || busy_o) && c < budget) begin
      step();
      c++;
    end
    total++;
    if (c >= budget) begin
      bad++;
      $display("FAIL drain: still busy after %0d cycles, required idle", budget);
    end
  endtask

  initial begin
    int cyc;
    int p1_before;
    int g_start [NREQ];
    int p_start [NREQ];
    int done_start;
    int c;
    int diff;
    logic [127:0] d;
    logic [NREQ-1:0] g;

    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0; auto_req[i] = 0; p_addr[i] = '0; p_data[i] = '0; p_rw[i] = 0;
      pulses[i] = 0; dut_grants[i] = 0;
    end
    prev_gnt = '0;
    mem_lat = 3; mem_seen = 0; mem_hold = 0; mem_rand_lat = 0; spurious_en = 0;
    use_fixed = 0; fixed_data = '0;
    mem_rsp_i = '0;
    drive_reqs();
    model_reset();

    // Reset state, sampled while reset is held.
    #1;
    check("reset_mem_valid", mem_req_o.valid, 1'b0);
    check("reset_gnt", gnt_o, '0);
    check("reset_busy", busy_o, 1'b0);
    check("reset_err", err_o, 1'b0);
    apply_reset();

    // 1: single read, memory answers after 3 waiting cycles.
    use_fixed = 1; fixed_data = {16{8'hA5}}; mem_lat = 3;
    p1_before = pulses[1];
    set_req(0, 32'h0000_1000, '0, 1'b0);
    wait_ready(0, 20, cyc, d);
    check("t1_latency", cyc, 5);
    check("t1_data", d, {16{8'hA5}});
    step();
    check("t1_pulse_width", rsp_o[0].ready, 1'b0);
    check("t1_other_quiet", pulses[1] - p1_before, 0);
    use_fixed = 0;
    drain(20);

    // 2: collision after reset; requester 0 re-raises at once so the second pick is a real tie.
    apply_reset();
    mem_lat = 2;
    new_req(0);
    new_req(1);
    drive_reqs();
    auto_req[0] = 1;
    wait_grant(20, g);
    check("t2_first", g, 2'b01);
    wait_grant(20, g);
    check("t2_second_tie_rr1", g, 2'b10);
    wait_grant(20, g);
    check("t2_third", g, 2'b01);
    auto_req[0] = 0;
    drain(40);

    // 3: write passthrough.
    mem_lat = 4;
    set_req(1, 32'h0000_2040, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 1'b1);
    wait_grant(20, g);
    check("t3_gnt", g, 2'b10);
    check("t3_addr", mem_req_o.addr, 32'h0000_2040);
    check("t3_data", mem_req_o.data, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
    check("t3_rw", mem_req_o.rw, 1'b1);
    check("t3_valid", mem_req_o.valid, 1'b1);
    wait_ready(1, 20, cyc, d);
    check("t3_latency", cyc, 5);
    drain(20);

    // 4: watchdog with memory stalled, then a late response.
    mem_hold = 1;
    set_req(0, 32'h0000_3000, '0, 1'b0);
    wait_grant(20, g);
    repeat (7) step();
    check("t4_err_before", err_o, 1'b0);
    step();
    check("t4_err_after8", err_o, 1'b1);
    check("t4_valid_held", mem_req_o.valid, 1'b1);
    repeat (5) step();
    mem_hold = 0;
    wait_ready(0, 20, cyc, d);
    check("t4_late_data", d, exp_word(32'h0000_3000));
    drain(20);
    check("t4_err_sticky", err_o, 1'b1);

    // 5: asynchronous reset in the middle of a transaction.
    mem_hold = 1;
    set_req(0, 32'h0000_4000, '0, 1'b0);
    wait_grant(20, g);
    step();
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    check("t5_valid_async", mem_req_o.valid, 1'b0);
    check("t5_gnt_async", gnt_o, '0);
    check("t5_err_async", err_o, 1'b0);
    check("t5_busy_async", busy_o, 1'b0);
    model_reset();
    mem_hold = 0;
    set_req(1, 32'h0000_5000, '0, 1'b0);
    step();
    step();
    rst_ni = 1'b1;
    wait_grant(20, g);
    check("t5_prio_after_reset", g, 2'b01);
    drain(40);

    // 6: fairness soak, both requesters always asking, random latency and stray ready pulses.
    for (int i = 0; i < NREQ; i++) begin
      g_start[i] = dut_grants[i];
      p_start[i] = pulses[i];
      auto_req[i] = 1;
    end
    mem_rand_lat = 1;
    spurious_en = 1;
    done_start = pulses[0] + pulses[1];
    c = 0;
    while ((pulses[0] + pulses[1] - done_start) < 1000 && c < 20000) begin
      step();
      c++;
    end
    total++;
    if (c >= 20000) begin
      bad++;
      $display("FAIL soak_budget: %0d transactions, required 1000", pulses[0] + pulses[1] - done_start);
    end
    for (int i = 0; i < NREQ; i++) auto_req[i] = 0;
    drain(100);
    diff = (dut_grants[0] - g_start[0]) - (dut_grants[1] - g_start[1]);
    check("soak_fair", (diff >= -1 && diff <= 1), 1'b1);
    for (int i = 0; i < NREQ; i++)
      check($sformatf("soak_pulses_eq_grants%0d", i), pulses[i] - p_start[i], dut_grants[i] - g_start[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
